mem_bus_ctrl: RTL

//  Memory-side controller between the multicycle datapath and a variable-latency word memory.

---
 rtl/mips_mc_pkg.sv | 16 +
 rtl/mem_bus_ctrl_if.sv | 22 ++
 rtl/mem_wait_timer.sv | 28 ++
 rtl/mem_bus_ctrl.sv | 125 ++++++++++++
 4 files changed

// File: rtl/mips_mc_pkg.sv
// Shared types for the multicycle MIPS memory-side blocks.
package mips_mc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

  function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
    return (addr_lsb & WORD_ALIGN_MASK) == 2'b00;
  endfunction

endpackage

// File: rtl/mem_bus_ctrl_if.sv
// Request/ack bus between the memory-side controller and a word memory.
interface mem_bus_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_addr, mem_wdata, mem_req, mem_we,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_req, mem_we,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/mem_wait_timer.sv
// Saturating wait counter; o_expired flags the last cycle allowed before timeout.
module mem_wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SAT_VAL   = CNT_W'(TIMEOUT);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != SAT_VAL)) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Expiring one count early means the count reaches TIMEOUT on the same edge we leave.
  assign o_expired = i_enable && (r_count >= LAST_WAIT);

endmodule

// File: rtl/mem_bus_ctrl.sv
// Memory-side controller: address mux, req/ack handshake, stall and read-data return.
module mem_bus_ctrl
  import mips_mc_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_out,
  input  logic [ADDR_W-1:0] alu_ou_result,
  input  logic [DATA_W-1:0] B_out,
  input  logic              IorD,
  input  logic              MemRead,
  input  logic              MemWrite,
  mem_bus_ctrl_if.master    mem_bus,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              stall,
  output logic              align_err,
  output logic              bus_err
);
  state_t            r_state, w_state_next;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_data_out;
  logic              r_we;
  logic              r_align_err;
  logic              r_bus_err;

  logic [ADDR_W-1:0] w_sel_addr;
  logic              w_req, w_conflict, w_misalign, w_start;
  logic              w_in_access, w_expired;
  logic              w_mem_req, w_stall, w_data_valid;

  assign w_sel_addr  = IorD ? alu_ou_result : pc_out;
  assign w_req       = MemRead | MemWrite;
  assign w_conflict  = MemRead & MemWrite;
  assign w_misalign  = !is_word_aligned(w_sel_addr[1:0]);
  assign w_start     = w_req && !w_conflict && !w_misalign;
  assign w_in_access = (r_state == ACCESS);

  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (!w_in_access),
    .i_enable  (w_in_access),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_start) w_state_next = ACCESS;
      ACCESS:  if (mem_bus.mem_ack || w_expired) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Stall rises combinationally with an accepted request so the control FSM freezes that cycle.
  always_comb begin
    w_mem_req    = 1'b0;
    w_stall      = 1'b0;
    w_data_valid = 1'b0;
    case (r_state)
      IDLE:    w_stall = w_start && !rst;
      ACCESS:  begin
        w_mem_req = 1'b1;
        w_stall   = 1'b1;
      end
      DONE:    w_data_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr      <= '0;
      r_wdata     <= '0;
      r_we        <= 1'b0;
      r_data_out  <= '0;
      r_align_err <= 1'b0;
      r_bus_err   <= 1'b0;
    end else begin
      if (r_state == IDLE && w_req) begin
        if (w_conflict) begin
          r_bus_err <= 1'b1;
        end else if (w_misalign) begin
          r_align_err <= 1'b1;
        end else begin
          r_addr  <= w_sel_addr;
          r_we    <= MemWrite;
          r_wdata <= B_out;
        end
      end
      // An ack arriving on the expiry cycle still completes the access cleanly.
      if (w_in_access) begin
        if (mem_bus.mem_ack) begin
          if (!r_we) r_data_out <= mem_bus.mem_rdata;
        end else if (w_expired) begin
          r_bus_err <= 1'b1;
        end
      end
    end
  end

  assign mem_bus.mem_addr  = r_addr;
  assign mem_bus.mem_wdata = r_wdata;
  assign mem_bus.mem_we    = r_we;
  assign mem_bus.mem_req   = w_mem_req;

  assign data_out   = r_data_out;
  assign data_valid = w_data_valid;
  assign stall      = w_stall;
  assign align_err  = r_align_err;
  assign bus_err    = r_bus_err;

endmodule
